// File: rtl/fibo_seq_ctrl.sv
// fibo_seq_ctrl: instruction sequencer for the Fibonacci datapath.
// Issues LOAD/OUT/ADD/NOP instructions, one per clock, so that the register
// file emits the first n Fibonacci terms. R0/R1 hold the running pair.
// Optional build macro: FIBO_STEP_EN adds a 'step' input that gates FSM
// advancement in the active states (stalled cycles issue NOP).
module fibo_seq_ctrl #(
    parameter int CNT_W  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  n,
`ifdef FIBO_STEP_EN
    input  logic              step,
`endif
    output logic [2:0]        opcode,
    output logic [1:0]        operand1,
    output logic [1:0]        operand2,
    output logic [DATA_W-1:0] ld_val,
    output logic              busy,
    output logic              done,
    output logic              term_valid,
    output logic [CNT_W-1:0]  term_idx
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_LOAD = 3'b100;
    localparam logic [2:0] OP_OUT  = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LD0  = 3'd1,
        S_LD1  = 3'd2,
        S_OUT  = 3'd3,
        S_ADD  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    n_lat_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_inc_s;
    logic                adv_s;
    logic [2:0]          opcode_r;
    logic [1:0]          operand1_r;
    logic [1:0]          operand2_r;
    logic [DATA_W-1:0]   ld_val_r;
    logic                busy_r;
    logic                done_r;
    logic                term_valid_r;

    assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef FIBO_STEP_EN
    assign adv_s = step;
`else
    assign adv_s = 1'b1;
`endif

    // Sequencer FSM; instruction outputs are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            n_lat_r      <= {CNT_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            opcode_r     <= OP_NOP;
            operand1_r   <= 2'b00;
            operand2_r   <= 2'b00;
            ld_val_r     <= {DATA_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            term_valid_r <= 1'b0;
        end else begin
            // Every cycle defaults to a NOP; only a real transition issues work
            opcode_r     <= OP_NOP;
            operand1_r   <= 2'b00;
            operand2_r   <= 2'b00;
            ld_val_r     <= {DATA_W{1'b0}};
            done_r       <= 1'b0;
            term_valid_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    busy_r <= 1'b0;
                    if (start) begin
                        n_lat_r <= n;
                        cnt_r   <= {CNT_W{1'b0}};
                        if (n != {CNT_W{1'b0}}) begin
                            state_r  <= S_LD0;
                            busy_r   <= 1'b1;
                            opcode_r <= OP_LOAD;
                        end else begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
                S_LD0, S_LD1, S_OUT, S_ADD: begin
                    if (abort) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end else if (!adv_s) begin
                        // Stalled: hold state, keep busy, issue NOP
                        state_r <= state_r;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r <= 1'b1;
                        case (state_r)
                            S_LD0: begin
                                state_r    <= S_LD1;
                                opcode_r   <= OP_LOAD;
                                operand1_r <= 2'b01;
                                ld_val_r   <= {{(DATA_W-1){1'b0}}, 1'b1};
                            end
                            S_LD1: begin
                                state_r      <= S_OUT;
                                opcode_r     <= OP_OUT;
                                operand1_r   <= 2'b00;
                                term_valid_r <= 1'b1;
                            end
                            S_OUT: begin
                                cnt_r <= cnt_inc_s;
                                if (cnt_inc_s == n_lat_r) begin
                                    state_r <= S_DONE;
                                    busy_r  <= 1'b0;
                                    done_r  <= 1'b1;
                                end else if (cnt_r == {CNT_W{1'b0}}) begin
                                    // Second term is R1 straight from its load
                                    state_r      <= S_OUT;
                                    opcode_r     <= OP_OUT;
                                    operand1_r   <= {1'b0, cnt_inc_s[0]};
                                    term_valid_r <= 1'b1;
                                end else begin
                                    // Destination is the register the next OUT emits
                                    state_r    <= S_ADD;
                                    opcode_r   <= OP_ADD;
                                    operand1_r <= {1'b0, cnt_inc_s[0]};
                                    operand2_r <= {1'b0, ~cnt_inc_s[0]};
                                end
                            end
                            S_ADD: begin
                                state_r      <= S_OUT;
                                opcode_r     <= OP_OUT;
                                operand1_r   <= {1'b0, cnt_r[0]};
                                term_valid_r <= 1'b1;
                            end
                            default: begin
                                state_r <= S_IDLE;
                                busy_r  <= 1'b0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign opcode     = opcode_r;
    assign operand1   = operand1_r;
    assign operand2   = operand2_r;
    assign ld_val     = ld_val_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign term_valid = term_valid_r;
    assign term_idx   = cnt_r;

endmodule

// File: tb/tb_fibo_seq_ctrl.sv
// Self-checking bench for fibo_seq_ctrl: the expected instruction stream is
// built from the sequencing rules, a register-file model executes the issued
// instructions and emitted values are compared with arithmetic Fibonacci.
module tb_fibo_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] n;
`ifdef FIBO_STEP_EN
    logic       step;
`endif
    logic [2:0] opcode;
    logic [1:0] operand1;
    logic [1:0] operand2;
    logic [7:0] ld_val;
    logic       busy;
    logic       done;
    logic       term_valid;
    logic [7:0] term_idx;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] o1;
        logic [1:0] o2;
        logic [7:0] lv;
        logic       busy;
        logic       done;
        logic       tv;
        logic [7:0] idx;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rf  [4];
    logic [7:0] fib [256];

    fibo_seq_ctrl #(.CNT_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .n          (n),
`ifdef FIBO_STEP_EN
        .step       (step),
`endif
        .opcode     (opcode),
        .operand1   (operand1),
        .operand2   (operand2),
        .ld_val     (ld_val),
        .busy       (busy),
        .done       (done),
        .term_valid (term_valid),
        .term_idx   (term_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [2:0] op, input int o1, input int o2,
                                input int lv, input bit b, input bit d, input bit tv,
                                input int idx);
        exp_t e;
        e.op = op; e.o1 = 2'(o1); e.o2 = 2'(o2); e.lv = 8'(lv);
        e.busy = b; e.done = d; e.tv = tv; e.idx = 8'(idx);
        return e;
    endfunction

    // Expected instruction stream for one run of n terms
    task automatic build(input int nv);
        exp_q.delete();
        if (nv != 0) begin
            exp_q.push_back(mk(3'b100, 0, 0, 0, 1'b1, 1'b0, 1'b0, 0));
            exp_q.push_back(mk(3'b100, 1, 0, 1, 1'b1, 1'b0, 1'b0, 0));
            for (int k = 0; k < nv; k++) begin
                if (k >= 2)
                    exp_q.push_back(mk(3'b001, k % 2, 1 - (k % 2), 0, 1'b1, 1'b0, 1'b0, 0));
                exp_q.push_back(mk(3'b101, k % 2, 0, 0, 1'b1, 1'b0, 1'b1, k));
            end
        end
        exp_q.push_back(mk(3'b000, 0, 0, 0, 1'b0, 1'b1, 1'b0, 0));
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_cycle(input string tag, input exp_t e);
        logic [25:0] obs;
        obs = {opcode, operand1, operand2, ld_val, busy, done, term_valid,
               (e.tv ? term_idx : 8'h00)};
        chk(tag, {6'd0, obs}, {6'd0, e});
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk(tag, {26'd0, opcode, busy, done, term_valid}, 32'd0);
    endtask

    // One complete run: start, then compare every issued cycle
    task automatic run_seq(input int nv, input bit disturb, input bit do_abort, input bit step_mode);
        int  p       = 0;
        int  ab      = -1;
        int  outs    = 0;
        int  cyc     = 0;
        bit  active  = 1'b0;
        bit  stepped = 1'b1;
        bit  aborted = 1'b0;
        exp_t e;
        build(nv);
        if (do_abort) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].tv) begin
                    outs++;
                    if (outs == 3 && ab < 0) ab = i;
                end
            end
        end
        for (int r = 0; r < 4; r++) rf[r] = 8'h00;
        n     = 8'(nv);
        start = 1'b1;
        while (p < exp_q.size() && !aborted) begin
            @(negedge clk);
            cyc++;
            if (cyc > 3000) begin
                total++;
                bad++;
                $error("FAIL timeout n=%0d observed=%0d expected=%0d", nv, p, exp_q.size());
                break;
            end
            if (abort) begin
                chk("abort_idle", {26'd0, opcode, busy, done, term_valid}, 32'd0);
                abort   = 1'b0;
                aborted = 1'b1;
            end else if (!active || stepped) begin
                e = exp_q[p];
                chk_cycle($sformatf("n%0d_i%0d", nv, p), e);
                if (p == ab) abort = 1'b1;
                active = e.busy;
                p++;
            end else begin
                e = mk(3'b000, 0, 0, 0, 1'b1, 1'b0, 1'b0, 0);
                chk_cycle($sformatf("stall_c%0d", cyc), e);
            end
            // Execute the issued instruction on the register-file model
            case (opcode)
                3'b001:  rf[operand1] = rf[operand1] + rf[operand2];
                3'b100:  rf[operand1] = ld_val;
                3'b101:  if (e.tv && !aborted) chk($sformatf("val_t%0d", e.idx), {24'd0, rf[operand1]}, {24'd0, fib[e.idx]});
                default: ;
            endcase
            stepped = step_mode ? ((cyc % 3) == 0) : 1'b1;
`ifdef FIBO_STEP_EN
            step = stepped;
`endif
            start = disturb && active;
            if (disturb) n = 8'($urandom);
        end
        start = 1'b0;
        abort = 1'b0;
`ifdef FIBO_STEP_EN
        step = 1'b1;
`endif
    endtask

    initial begin
        fib[0] = 8'd0;
        fib[1] = 8'd1;
        for (int k = 2; k < 256; k++) fib[k] = fib[k-1] + fib[k-2];

        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        n     = 8'd0;
`ifdef FIBO_STEP_EN
        step  = 1'b1;
`endif
        repeat (2) @(negedge clk);
        chk("reset_state", {6'd0, opcode, operand1, operand2, ld_val, busy, done, term_valid, term_idx}, 32'd0);
        rst = 1'b0;
        idle_chk("idle_after_reset");

        run_seq(0, 1'b0, 1'b0, 1'b0);
        idle_chk("idle_n0");
        run_seq(1, 1'b0, 1'b0, 1'b0);
        idle_chk("idle_n1");
        run_seq(7, 1'b0, 1'b0, 1'b0);
        idle_chk("idle_n7");
        run_seq(5, 1'b1, 1'b0, 1'b0);
        idle_chk("idle_n5_disturb");
        run_seq(5, 1'b0, 1'b1, 1'b0);
        idle_chk("idle_n5_abort");

        // Abort while idle must not start anything
        abort = 1'b1;
        idle_chk("abort_in_idle");
        abort = 1'b0;

        // Reset asserted during the first ADD
        n     = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_add", {29'd0, opcode}, 32'd1);
        rst = 1'b1;
        #1;
        chk("reset_midrun", {26'd0, opcode, busy, done, term_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_chk("idle_after_midreset");
        run_seq(7, 1'b0, 1'b0, 1'b0);
        idle_chk("idle_rerun");

        run_seq(255, 1'b0, 1'b0, 1'b0);
        idle_chk("idle_n255");

        for (int r = 0; r < 8; r++) begin
            run_seq(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            idle_chk("idle_rand");
        end

`ifdef FIBO_STEP_EN
        run_seq(3, 1'b0, 1'b0, 1'b1);
        idle_chk("idle_step");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fibo_seq_ctrl.md
# fibo_seq_ctrl

Instruction sequencer for the Fibonacci datapath. On a start request it issues, one instruction per clock, the opcode/operand stream that the instruction decoder turns into ALU, register-file and load controls, producing the first N Fibonacci terms on the register-file output. It sits between the top-level control (start/abort/done handshake) and the decoder; registers R0/R1 hold the running pair, and R2/R3 are unused.

## Interface
- CNT_W, 8, width of term count `n` and `term_idx`
- DATA_W, 8, width of `ld_val` (matches datapath register width)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- abort  in  1  synchronous cancel of a running sequence
- n  in  CNT_W  number of terms to emit; latched on accepted start
- opcode  out  3  instruction to decoder: 000 NOP, 001 ADD, 100 LOAD, 101 OUT
- operand1  out  2  destination / first source register
- operand2  out  2  second source register
- ld_val  out  DATA_W  constant for LOAD (0 or 1), else 0
- busy  out  1  high from cycle after accepted start until done/abort
- done  out  1  one-cycle pulse at sequence end
- term_valid  out  1  high in every OUT cycle
- term_idx  out  CNT_W  index of term emitted in OUT cycle (0-based)
- step  in  1  only when FIBO_STEP_EN defined (see Configuration)

## Operation
- All outputs registered (Moore); opcode/operands decoded from state register.
- Opcode semantics: ADD r[op1]=r[op1]+r[op2]; LOAD r[op1]=ld_val; OUT emits r[op1], no write; NOP no write.
- States: IDLE, LD0, LD1, OUT, ADD, DONE.
- IDLE: outputs NOP/00/00, busy=0. start=1 -> latch n, term counter=0; next LD0 if n≠0, else DONE.
- LD0: LOAD R0, ld_val=0. -> LD1.
- LD1: LOAD R1, ld_val=1. -> OUT.
- OUT: opcode 101, operand1 = R0 when term_idx even, R1 when odd; term_valid=1. After it, counter increments; if counter == n -> DONE; else if term_idx == 0 -> OUT (emits R1); else -> ADD.
- ADD: alternates destination: dest = register that will be emitted by the next OUT (even next index: ADD R0,R1; odd: ADD R1,R0). -> OUT.
- Resulting stream: LD R0,0; LD R1,1; OUT R0; OUT R1; ADD R0,R1; OUT R0; ADD R1,R0; OUT R1; ...
- DONE: NOP, done=1 for one cycle, busy=0. -> IDLE.
- start while busy: ignored. n latched; changes on `n` mid-run have no effect.
- abort=1 in any non-IDLE state: next cycle IDLE, NOP, no done pulse. abort in IDLE ignored; abort has priority over step.
- Term index arithmetic modulo 2^CNT_W; n max 2^CNT_W-1. Datapath overflow is not detected here.

## Timing
- Reset (async): state IDLE, opcode 000, operand1/2 00, ld_val 0, busy 0, done 0, term_valid 0, term_idx 0.
- start at cycle t: LD0 at t+1, LD1 t+2, first OUT t+3, second OUT t+4, then OUT every 2 cycles.
- n=0: DONE at t+1, no instruction issued. n=1: OUT t+3, done t+4. n≥2: last OUT t+4+2(n−2), done one cycle later.
- Earliest new start accepted the cycle after done (back in IDLE).
- rst mid-sequence: outputs return to reset values immediately; no done.

## Configuration
- FIBO_STEP_EN defined: `step` port exists; in non-IDLE, non-DONE states the FSM advances only in cycles where step=1; outputs NOP/term_valid=0 on stalled cycles so no instruction repeats; IDLE/DONE unaffected by step.
- FIBO_STEP_EN undefined: no `step` port; FSM advances every cycle as specified above.

## Test plan
- Reset mid-run (assert rst during ADD) -> opcode 000, busy 0, done 0 same cycle; next start runs full sequence.
- n=0, start -> done pulse exactly at t+1, no LOAD/OUT issued.
- n=1 -> LD0(100,00,val 0), LD1(100,01,val 1), OUT R0 with term_idx 0, done at t+4.
- n=7 -> OUT operands R0,R1,R0,R1,... term_idx 0..6; modeled register values 0,1,1,2,3,5,8; done at t+15.
- start pulses while busy and n changed mid-run (n=5 → 2) -> ignored, 5 terms emitted; abort during third OUT -> IDLE next cycle, no done.
- FIBO_STEP_EN, n=3, step every 3rd cycle -> identical instruction order, NOPs between steps, term values 0,1,1.
